// File: rtl/hazard_control_unit.sv
// rtl/hazard_control_unit.sv - load-use / redirect / MDU stall-flush sequencer
module hazard_control_unit #(
    parameter int MDU_TIMEOUT = 64,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       rs1_de,
    input  logic [4:0]       rs2_de,
    input  logic             uses_rs2_de,
    input  logic [4:0]       rd_ex,
    input  logic             DMRd_ex,
    input  logic             branch_taken_ex,
    input  logic             mdu_start_ex,
    input  logic             mdu_done,
    input  logic             stat_clr,
    output logic             stall_if,
    output logic             stall_de,
    output logic             flush_de,
    output logic             stall_ex,
    output logic             flush_ex,
    output logic             flush_me,
    output logic             mdu_busy,
    output logic             mdu_abort,
    output logic             mdu_timeout,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam int BW = $clog2(MDU_TIMEOUT + 1);
    localparam logic [BW-1:0] TMO = BW'(MDU_TIMEOUT);

    localparam logic ST_RUN  = 1'b0;
    localparam logic ST_BUSY = 1'b1;

    logic          state;
    logic          state_nxt;
    logic [BW-1:0] busy_cnt;
    logic [BW-1:0] busy_cnt_nxt;
    logic          load_use;

    logic          s_if, s_de, f_de, s_ex, f_ex, f_me, abort;

    assign load_use = DMRd_ex && (rd_ex != 5'd0) &&
                      ((rd_ex == rs1_de) || (uses_rs2_de && (rd_ex == rs2_de)));

    always_comb begin
        state_nxt    = state;
        busy_cnt_nxt = busy_cnt;
        s_if  = 1'b0;
        s_de  = 1'b0;
        f_de  = 1'b0;
        s_ex  = 1'b0;
        f_ex  = 1'b0;
        f_me  = 1'b0;
        abort = 1'b0;
        if (state == ST_RUN) begin
            if (branch_taken_ex) begin
                f_de = 1'b1;
                f_ex = 1'b1;
            end else if (mdu_start_ex) begin
                s_if         = 1'b1;
                s_de         = 1'b1;
                s_ex         = 1'b1;
                f_me         = 1'b1;
                state_nxt    = ST_BUSY;
                busy_cnt_nxt = BW'(1);
            end else if (load_use) begin
                // One bubble suffices: next cycle EX holds the NOP, clearing the match.
                s_if = 1'b1;
                s_de = 1'b1;
                f_ex = 1'b1;
            end
        end else begin
            if (mdu_done) begin
                state_nxt    = ST_RUN;
                busy_cnt_nxt = '0;
            end else if (busy_cnt < TMO) begin
                s_if         = 1'b1;
                s_de         = 1'b1;
                s_ex         = 1'b1;
                f_me         = 1'b1;
                busy_cnt_nxt = busy_cnt + BW'(1);
            end else begin
                abort        = 1'b1;
                state_nxt    = ST_RUN;
                busy_cnt_nxt = '0;
            end
        end
    end

    // Combinational controls are forced low while reset is held.
    assign stall_if  = rst_n & s_if;
    assign stall_de  = rst_n & s_de;
    assign flush_de  = rst_n & f_de;
    assign stall_ex  = rst_n & s_ex;
    assign flush_ex  = rst_n & f_ex;
    assign flush_me  = rst_n & f_me;
    assign mdu_abort = rst_n & abort;
    assign mdu_busy  = rst_n & (state == ST_BUSY);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_RUN;
            busy_cnt     <= '0;
            mdu_timeout  <= 1'b0;
            stall_cycles <= '0;
        end else begin
            state    <= state_nxt;
            busy_cnt <= busy_cnt_nxt;
            if (abort)
                mdu_timeout <= 1'b1;
            if (stat_clr)
                stall_cycles <= '0;
            else if (s_if && (stall_cycles != {CNT_W{1'b1}}))
                stall_cycles <= stall_cycles + CNT_W'(1);
        end
    end

endmodule
